toggle_cover_collector: RTL and testbench
=========================================

Name: toggle_cover_collector

Overview:
- Parametrised successor to the fixed 5-bit toggle cover stub.
- Detects real 0->1 and 1->0 transitions on a WIDTH-bit sampled bus and keeps sticky per-edge hit bitmaps.
- Drains each newly covered point exactly once over a valid/ready report channel; a priority encoder plus an FSM serialise the reports.
- Sits beside the DUT signal being covered; the report channel feeds the cover aggregator or DPI bridge in the harness.

Parameters:
- WIDTH, 5, number of sampled bits; gives 2*WIDTH cover points.
- COVER_INDEX, 0, global index of point 0.
- COVER_TOTAL, 28338, global point count, used only for the elaboration check.
- IDX_W, 32, width of report_index.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  sampling enable.
- sample  in  WIDTH  monitored bus.
- report_valid  out  1  a cover report is presented.
- report_ready  in  1  consumer accepts the report.
- report_index  out  IDX_W  COVER_INDEX + point number.
- report_fall  out  1  0 = rise point, 1 = fall point.
- clear_req  in  1  request to clear all coverage state.
- clear_done  out  1  one-cycle pulse after the clear is applied.
- covered_count  out  clog2(2*WIDTH+1)  popcount of the hit bitmaps.
- all_covered  out  1  all 2*WIDTH points hit.

Behaviour:
- Reset (asynchronous, reset low) clears all state: prev, primed, rise_hit, fall_hit, pending, clr_pend. All outputs are 0 and the FSM is in IDLE.
- Point numbering:
  - Point p in [0, WIDTH) is the rise of bit p.
  - Point WIDTH+p is the fall of bit p.
  - report_fall = (point >= WIDTH).
- Sampling:
  - On each enabled clock, prev <= sample and primed <= 1.
  - Edges are evaluated only when enable && primed: rise = ~prev & sample, fall = prev & ~sample.
  - The first enabled cycle after reset, after a clear, or after enable was low only primes; it detects no edges.
  - A disabled cycle clears primed.
- Hit update:
  - hit |= edge.
  - A point whose hit bit was 0 and whose edge is detected sets its pending bit.
  - Multiple bits or edges in one cycle all register.
  - An already-hit point never sets pending again.
- Report FSM, states IDLE, REPORT, CLEAR:
  - IDLE -> REPORT when pending != 0 and clr_pend = 0.
  - On entry to REPORT, the lowest-numbered pending point is latched into report_index and report_fall, and report_valid is asserted on the next cycle edge. Minimum latency is 1 cycle from the edge being sampled to report_valid high.
  - In REPORT, report_valid, report_index and report_fall stay stable until report_valid && report_ready. Points newly pended meanwhile never alter the presented report.
  - On the handshake, that point's pending bit is cleared and the FSM goes to CLEAR if clr_pend is set, otherwise to REPORT with the next lowest pending point (back-to-back reports, no bubble), otherwise to IDLE.
  - Sustained ready gives one report per cycle.
- Clear:
  - clear_req sets clr_pend (it is a level or a pulse; either is latched).
  - From IDLE, the FSM enters CLEAR next cycle. From REPORT, it waits for the in-flight handshake; an in-flight report is never dropped.
  - CLEAR lasts one cycle: it zeroes hit, pending, primed and clr_pend.
  - Edges in the CLEAR cycle are discarded.
  - clear_done pulses high in the cycle after CLEAR, and the FSM returns to IDLE.
  - clear_req asserted during CLEAR is absorbed and does not cause a second clear.
- covered_count and all_covered are registered from the hit bitmaps and lag the hit update by 0 cycles; both read 0 after a clear.
- Elaboration error if COVER_INDEX + 2*WIDTH > COVER_TOTAL, or if WIDTH < 1.

Test Plan (WIDTH=5, COVER_INDEX=100 unless noted):
- Priming: reset, then enable=1 with sample=5'h1F held -> no report; covered_count=0.
- Single rise: sample 0x00 -> 0x04 with ready=1 -> one report, index=102, fall=0; covered_count=1; no second report when 0x04 -> 0x00 -> 0x04 repeats the rise.
- Simultaneous edges: 0x00 -> 0x1F -> 0x00 with ready=1 -> reports index 100..104 then 105..109, fall bit correct; all_covered=1; covered_count=10.
- Backpressure: ready=0 while a rise of bit 3 and then bit 1 occur -> valid held, index=103 stable for 20 cycles; after ready=1, index=103 is accepted, then 101.
- Clear during report: clear_req while index=103 is presented with ready=0 -> no clear until the handshake; clear_done pulses 2 cycles after it; covered_count=0; a re-toggle of bit 3 is reported again.
- Async reset mid-report: reset low while valid is high -> report_valid=0 immediately; bitmaps are 0 after release.

Source files
------------

// File: rtl/toggle_cover_collector.sv
// Toggle coverage collector: sticky rise/fall hit bitmaps per sampled bit,
// with each newly covered point drained once over a valid/ready channel.
module toggle_cover_collector #(
  parameter int WIDTH       = 5,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 28338,
  parameter int IDX_W       = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [WIDTH-1:0]               sample,
  output logic                           report_valid,
  input  logic                           report_ready,
  output logic [IDX_W-1:0]               report_index,
  output logic                           report_fall,
  input  logic                           clear_req,
  output logic                           clear_done,
  output logic [$clog2(2*WIDTH+1)-1:0]   covered_count,
  output logic                           all_covered
);

  localparam int unsigned N  = 2 * WIDTH;
  localparam int          PW = $clog2(N);
  localparam int          CW = $clog2(2*WIDTH+1);

  if (WIDTH < 1 || COVER_INDEX + 2*WIDTH > COVER_TOTAL) begin : g_param_check
    $error("toggle_cover_collector: bad WIDTH/COVER_INDEX/COVER_TOTAL");
  end

  typedef enum logic [1:0] {IDLE, REPORT, CLEAR} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] prev;
  logic             primed;
  logic [N-1:0]     hit, pending;
  logic             clr_pend;
  logic [PW-1:0]    cur_pt, pick;
  logic             found;
  logic [N-1:0]     edges, hit_nx, pend_set, ack_mask, cand;
  logic             load, ack, do_clear;
  logic [CW-1:0]    count_nx;

  // Bits [WIDTH-1:0] are rise points, [2*WIDTH-1:WIDTH] are fall points.
  always_comb begin
    edges = '0;
    if (enable && primed && state != CLEAR)
      edges = {prev & ~sample, ~prev & sample};
    hit_nx   = do_clear ? '0 : (hit | edges);
    pend_set = edges & ~hit;
  end

  always_comb begin
    ack_mask = '0;
    for (int unsigned i = 0; i < N; i++)
      ack_mask[i] = (cur_pt == PW'(i));
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    ack      = 1'b0;
    do_clear = 1'b0;
    case (state)
      IDLE: begin
        if (clr_pend) state_nx = CLEAR;
        else if (pending != '0) begin
          state_nx = REPORT;
          load     = 1'b1;
        end
      end
      REPORT: begin
        if (report_ready) begin
          ack = 1'b1;
          if (clr_pend) state_nx = CLEAR;
          else if ((pending & ~ack_mask) != '0) begin
            state_nx = REPORT;
            load     = 1'b1;
          end else state_nx = IDLE;
        end
      end
      CLEAR: begin
        do_clear = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Candidates exclude the point being acknowledged so back-to-back reports skip it.
  always_comb begin
    cand  = ack ? (pending & ~ack_mask) : pending;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && cand[i]) begin
        pick  = PW'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    count_nx = '0;
    for (int unsigned i = 0; i < N; i++)
      count_nx = count_nx + CW'(hit_nx[i]);
  end

  assign report_valid = (state == REPORT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      prev          <= '0;
      primed        <= 1'b0;
      hit           <= '0;
      pending       <= '0;
      clr_pend      <= 1'b0;
      cur_pt        <= '0;
      report_index  <= '0;
      report_fall   <= 1'b0;
      clear_done    <= 1'b0;
      covered_count <= '0;
      all_covered   <= 1'b0;
    end else begin
      state      <= state_nx;
      primed     <= do_clear ? 1'b0 : enable;
      if (enable) prev <= sample;
      hit        <= hit_nx;
      pending    <= do_clear ? '0 : (cand | pend_set);
      clr_pend   <= do_clear ? 1'b0 : (clr_pend | clear_req);
      clear_done <= do_clear;
      if (load) begin
        cur_pt       <= pick;
        report_index <= IDX_W'(COVER_INDEX) + IDX_W'(pick);
        report_fall  <= int'(pick) >= WIDTH;
      end
      covered_count <= count_nx;
      all_covered   <= &hit_nx;
    end
  end

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Bench for toggle_cover_collector: vector table with a report scoreboard,
// plus hand-written backpressure, clear and async-reset sequences.
module tb_toggle_cover_collector;

  localparam int W    = 5;
  localparam int BASE = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [4:0] sample = '0;
  logic       report_valid;
  logic       report_ready = 1'b0;
  logic [31:0] report_index;
  logic       report_fall;
  logic       clear_req = 1'b0;
  logic       clear_done;
  logic [3:0] covered_count;
  logic       all_covered;

  toggle_cover_collector #(
    .WIDTH(W), .COVER_INDEX(BASE), .COVER_TOTAL(28338), .IDX_W(32)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .sample(sample),
    .report_valid(report_valid), .report_ready(report_ready),
    .report_index(report_index), .report_fall(report_fall),
    .clear_req(clear_req), .clear_done(clear_done),
    .covered_count(covered_count), .all_covered(all_covered)
  );

  always #5 clock = ~clock;

  typedef struct { int idx; logic fall; } rep_t;
  typedef struct { logic en; logic [4:0] s; int cnt; logic all; } vec_t;

  rep_t q[$];
  int compared = 0;
  int mismatched = 0;

  logic [4:0] m_prev;
  logic       m_primed;
  logic [9:0] m_hit;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted report must match the oldest expected one.
  always @(negedge clock) begin
    if (reset && report_valid && report_ready) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_report: got index %0d fall %0b, none expected",
                 report_index, report_fall);
      end else begin
        rep_t e;
        e = q.pop_front();
        check("report_index", 64'(report_index), 64'(e.idx));
        check("report_fall", 64'(report_fall), 64'(e.fall));
      end
    end
  end

  task automatic model_reset();
    m_prev   = '0;
    m_primed = 1'b0;
    m_hit    = '0;
    q.delete();
  endtask

  // Applies inputs just after a posedge; returns at the negedge before they are sampled.
  task automatic step(input logic en, input logic [4:0] s);
    rep_t r;
    @(posedge clock); #1;
    enable = en;
    sample = s;
    if (en && m_primed) begin
      for (int i = 0; i < W; i++)
        if (!m_prev[i] && s[i] && !m_hit[i]) begin
          m_hit[i] = 1'b1; r.idx = BASE + i; r.fall = 1'b0; q.push_back(r);
        end
      for (int i = 0; i < W; i++)
        if (m_prev[i] && !s[i] && !m_hit[W+i]) begin
          m_hit[W+i] = 1'b1; r.idx = BASE + W + i; r.fall = 1'b1; q.push_back(r);
        end
    end
    if (en) m_prev = s;
    m_primed = en;
    @(negedge clock);
  endtask

  task automatic reset_dut();
    @(posedge clock); #1;
    reset = 1'b0;
    enable = 1'b0; sample = '0; report_ready = 1'b0; clear_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      if (q.size() == 0 && !report_valid) done = 1;
    end
    check({name, "_drained"}, 64'(done), 64'd1);
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = '{1'b1, 5'h1F, 0,  1'b0};
    vt[1]  = '{1'b1, 5'h1F, 0,  1'b0};
    vt[2]  = '{1'b0, 5'h00, 0,  1'b0};
    vt[3]  = '{1'b1, 5'h00, 0,  1'b0};
    vt[4]  = '{1'b1, 5'h04, 1,  1'b0};
    vt[5]  = '{1'b1, 5'h00, 2,  1'b0};
    vt[6]  = '{1'b1, 5'h04, 2,  1'b0};
    vt[7]  = '{1'b1, 5'h00, 2,  1'b0};
    vt[8]  = '{1'b1, 5'h1F, 6,  1'b0};
    vt[9]  = '{1'b1, 5'h00, 10, 1'b1};
    vt[10] = '{1'b1, 5'h1F, 10, 1'b1};

    reset_dut();
    check("rst_valid", 64'(report_valid), 64'd0);
    check("rst_index", 64'(report_index), 64'd0);
    check("rst_fall", 64'(report_fall), 64'd0);
    check("rst_count", 64'(covered_count), 64'd0);
    check("rst_all", 64'(all_covered), 64'd0);
    check("rst_clear_done", 64'(clear_done), 64'd0);

    // Table: priming, single rise/fall, repeated toggles, simultaneous edges.
    report_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step(vt[k].en, vt[k].s);
      @(negedge clock);
      check($sformatf("vec%0d_count", k), 64'(covered_count), 64'(vt[k].cnt));
      check($sformatf("vec%0d_all", k), 64'(all_covered), 64'(vt[k].all));
    end
    wait_drain("table");

    // Backpressure: 103 presented and stable, 101 queued behind it.
    reset_dut();
    step(1'b1, 5'h00);
    step(1'b1, 5'h08);
    step(1'b1, 5'h0A);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      check("bp_valid", 64'(report_valid), 64'd1);
      check("bp_index", 64'(report_index), 64'd103);
    end
    @(posedge clock); #1 report_ready = 1'b1;
    wait_drain("bp");
    check("bp_count", 64'(covered_count), 64'd2);

    // Clear requested while a report is stalled.
    reset_dut();
    step(1'b1, 5'h00);
    step(1'b1, 5'h08);
    repeat (3) @(negedge clock);
    @(posedge clock); #1 clear_req = 1'b1;
    @(posedge clock); #1 clear_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("clr_hold_valid", 64'(report_valid), 64'd1);
      check("clr_hold_done", 64'(clear_done), 64'd0);
    end
    @(posedge clock); #1 report_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("clr_h1_done", 64'(clear_done), 64'd0);
    check("clr_h1_valid", 64'(report_valid), 64'd0);
    @(negedge clock);
    check("clr_h2_done", 64'(clear_done), 64'd1);
    check("clr_count", 64'(covered_count), 64'd0);
    @(negedge clock);
    check("clr_h3_done", 64'(clear_done), 64'd0);
    check("clr_q_empty", 64'(q.size()), 64'd0);
    m_hit = '0;
    step(1'b0, 5'h08);
    step(1'b1, 5'h00);
    step(1'b1, 5'h08);
    wait_drain("clr_retoggle");
    check("clr_retoggle_count", 64'(covered_count), 64'd1);

    // Asynchronous reset while a report is presented.
    reset_dut();
    step(1'b1, 5'h00);
    step(1'b1, 5'h10);
    begin
      bit seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clock);
        if (report_valid) seen = 1;
      end
      check("ar_valid_seen", 64'(seen), 64'd1);
    end
    @(posedge clock); #2 reset = 1'b0;
    #1;
    check("ar_valid_now", 64'(report_valid), 64'd0);
    check("ar_count_now", 64'(covered_count), 64'd0);
    model_reset();
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    check("ar_valid_after", 64'(report_valid), 64'd0);
    check("ar_count_after", 64'(covered_count), 64'd0);
    check("ar_all_after", 64'(all_covered), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
